regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port integer register file with two write ports, N read ports, same-cycle write-to-read bypass and a per-register scoreboard of pending writes. It replaces the single-write/two-read register file in the core's decode/writeback path. It lets an ALU writeback and a load writeback retire in the same cycle, and lets decode stall on operands whose producer has not yet written back.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = index 0 reads 0, ignores writes and marks
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- wen0 / waddr0 / wdata0  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 0 (ALU writeback)
- wen1 / waddr1 / wdata1  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1 (load writeback)
- mark_en  in  1  set pending bit for mark_addr (decode issued an instruction writing it)
- mark_addr  in  ADDR_WIDTH  destination being marked
- ren  in  1  read enable, all read ports
- raddr  in  NUM_RD*ADDR_WIDTH  read indices, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_RD*DATA_WIDTH  read data, packed the same way
- rbusy  out  NUM_RD  port k operand still pending (decode must stall)
- pending_cnt  out  ADDR_WIDTH+1  number of set pending bits
- dbg_addr  in  ADDR_WIDTH  difftest/debug read index
- dbg_data  out  DATA_WIDTH  debug read data, no bypass, ignores ren

## Operation
- Storage: rf[0..2**ADDR_WIDTH-1], pend[0..2**ADDR_WIDTH-1], cnt register.
- Reset (rst=0 at edge): every rf entry, pend bit and cnt go to 0. Reset overrides all writes and marks in that cycle.
- Write: on edge, wenX updates rf[waddrX]. Both ports to same index: port 1 wins. With ZERO_REG, writes to index 0 are dropped.
- Pending clear: on edge, a write on either port clears pend[waddrX].
- Pending set: on edge, mark_en sets pend[mark_addr]. Mark and write to the same index in the same cycle: mark wins, so the bit stays/becomes 1 (the new producer is younger). With ZERO_REG, mark of index 0 is dropped.
- cnt: next cnt = popcount of next pend. It is maintained incrementally (+1 for a set of a clear bit, -1 per distinct cleared set bit, net per the rules above). Range 0..2**ADDR_WIDTH, never wraps.
- Read port k, combinational:
  - ren=0 or (ZERO_REG and raddr_k=0) → rdata_k=0, rbusy_k=0.
  - else if BYPASS and a write in this cycle hits raddr_k → rdata_k = that wdata (port 1 over port 0), rbusy_k=0.
  - else rdata_k = rf[raddr_k], rbusy_k = pend[raddr_k].
- The same-cycle mark does not affect rbusy (registered state only).
- dbg_data = rf[dbg_addr], or 0 for index 0 when ZERO_REG.

## Timing
- Reads, rbusy, dbg_data: 0-cycle combinational from addresses and current state (plus write inputs when BYPASS=1).
- Write visible on non-bypassed reads 1 cycle after the edge that commits it. With BYPASS=1 it is visible in the same cycle.
- Mark visible on rbusy the cycle after mark_en. Clear visible the cycle after the write, or the same cycle via bypass.
- pending_cnt is registered and matches popcount(pend) every cycle.
- Outputs during and immediately after reset: rdata=0, rbusy=0, pending_cnt=0, dbg_data=0.
- Reset mid-operation discards pending bits. In-flight writebacks arriving after reset write normally and clear nothing.

## Test plan
- Reset then dual write: rst=0 for 1 cycle; wen0 r3=0x11, wen1 r4=0x22. Next cycle raddr={3,4} → rdata={0x11,0x22}, pending_cnt=0.
- Write collision: wen0 and wen1 both to r7 (0xAAAA, 0x5555). Next cycle r7 reads 0x5555. Same-cycle read of r7 with BYPASS=1 → 0x5555.
- Zero register: write 0xFFFF_FFFF to r0 and mark r0 → r0 reads 0, rbusy=0, pending_cnt unchanged.
- Scoreboard: mark r5 → next cycle rbusy for r5 =1, pending_cnt=1. wen0 r5=0x99 → same cycle rdata=0x99, rbusy=0. Next cycle pend cleared, cnt=0.
- Mark/write race: pend[r6]=1; same cycle wen1 r6=0x1 and mark r6 → r6 stays pending, rf[r6]=0x1, cnt unchanged at 1.
- Mid-operation reset: mark r1, r2, r3 (cnt=3); assert rst → cnt=0, all rbusy=0, all rdata=0. dbg_data for r3 = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports with
// same-cycle write bypass, and a per-register pending-write scoreboard with a live count.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic                         mark_en,
  input  logic [ADDR_WIDTH-1:0]        mark_addr,
  input  logic                         ren,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  output logic [ADDR_WIDTH:0]          pending_cnt,
  input  logic [ADDR_WIDTH-1:0]        dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic wr0_ok, wr1_ok, mark_ok;
  logic set_new, clr0, clr1;

  assign wr0_ok  = wen0 && ((ZERO_REG == 0) || (waddr0 != '0));
  assign wr1_ok  = wen1 && ((ZERO_REG == 0) || (waddr1 != '0));
  assign mark_ok = mark_en && ((ZERO_REG == 0) || (mark_addr != '0));

  always_comb begin
    rf_d = rf_q;
    if (wr0_ok) rf_d[waddr0] = wdata0;
    if (wr1_ok) rf_d[waddr1] = wdata1;

    // A mark lands after the clears: the marking instruction is the younger producer.
    pend_d = pend_q;
    if (wen0)    pend_d[waddr0]    = 1'b0;
    if (wen1)    pend_d[waddr1]    = 1'b0;
    if (mark_ok) pend_d[mark_addr] = 1'b1;

    // Each touched index contributes at most once to the count delta.
    set_new = mark_ok && !pend_q[mark_addr];
    clr0    = wen0 && pend_q[waddr0] && !(mark_ok && (waddr0 == mark_addr));
    clr1    = wen1 && pend_q[waddr1] && !(mark_ok && (waddr1 == mark_addr))
              && !(wen0 && (waddr0 == waddr1));
    cnt_d   = cnt_q + CW'(set_new) - CW'(clr0) - CW'(clr1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = rst ? cnt_q : '0;
  assign dbg_data    = (!rst || ((ZERO_REG != 0) && (dbg_addr == '0))) ? '0 : rf_q[dbg_addr];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_v;
    logic                  busy_v;
    logic                  hit0, hit1;

    assign ra   = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit0 = (BYPASS != 0) && wen0 && (waddr0 == ra);
    assign hit1 = (BYPASS != 0) && wen1 && (waddr1 == ra);

    always_comb begin
      rd_v   = '0;
      busy_v = 1'b0;
      if (!rst || !ren || ((ZERO_REG != 0) && (ra == '0))) begin
        rd_v   = '0;
        busy_v = 1'b0;
      end else if (hit1) begin
        rd_v = wdata1;
      end else if (hit0) begin
        rd_v = wdata0;
      end else begin
        rd_v   = rf_q[ra];
        busy_v = pend_q[ra];
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_v;
    assign rbusy[k]                          = busy_v;
  end

endmodule
